// File: rtl/jt12_pkg.sv
// Shared widths and algorithm codes for the FM output mixer.
package jt12_pkg;

    localparam int OP_W  = 14;
    localparam int OUT_W = 16;

    localparam logic [2:0] ALG_0 = 3'd0;
    localparam logic [2:0] ALG_1 = 3'd1;
    localparam logic [2:0] ALG_2 = 3'd2;
    localparam logic [2:0] ALG_3 = 3'd3;
    localparam logic [2:0] ALG_4 = 3'd4;
    localparam logic [2:0] ALG_5 = 3'd5;
    localparam logic [2:0] ALG_6 = 3'd6;
    localparam logic [2:0] ALG_7 = 3'd7;

endpackage

// File: rtl/jt12_accumulator_if.sv
// Per-slot operator stream into the mixer and the stereo sample out of it.
interface jt12_accumulator_if;
    import jt12_pkg::*;

    logic signed [OP_W-1:0]  op_result;
    logic        [1:0]       rl;
    logic                    s1_enters;
    logic                    s2_enters;
    logic                    s3_enters;
    logic                    s4_enters;
    logic        [2:0]       alg;
    logic signed [OUT_W-1:0] left;
    logic signed [OUT_W-1:0] right;

    modport master (
        output op_result, rl, s1_enters, s2_enters, s3_enters, s4_enters, alg,
        input  left, right
    );

    modport slave (
        input  op_result, rl, s1_enters, s2_enters, s3_enters, s4_enters, alg,
        output left, right
    );

endinterface

// File: rtl/jt12_sat16.sv
// Combinational clamp of a wide signed sum to the signed 16-bit sample range.
module jt12_sat16
    import jt12_pkg::*;
#(
    parameter int ACC_W = 19
) (
    input  logic signed [ACC_W-1:0] din_i,
    output logic signed [OUT_W-1:0] dout_o
);

    // Value fits when every bit from the 16-bit sign position upward agrees.
    logic [ACC_W-OUT_W:0] top_bits;
    logic                 fits;

    assign top_bits = din_i[ACC_W-1:OUT_W-1];
    assign fits     = (top_bits == '0) || (top_bits == '1);

    always_comb begin
        if (fits) begin
            dout_o = din_i[OUT_W-1:0];
        end else if (din_i[ACC_W-1]) begin
            dout_o = {1'b1, {(OUT_W-1){1'b0}}};
        end else begin
            dout_o = {1'b0, {(OUT_W-1){1'b1}}};
        end
    end

endmodule

// File: rtl/jt12_accumulator.sv
// FM output mixer: sums carrier slots per stereo side over a 24-slot frame and
// presents the saturated totals of the previous frame at each frame boundary.
module jt12_accumulator
    import jt12_pkg::*;
#(
    parameter int ACC_W = 19
) (
    input  logic              clk,
    input  logic              rst,
    jt12_accumulator_if.slave acc_if
);

    logic                    sum_en;
    logic                    frame_start;
    logic                    s1_last_q;
    logic signed [ACC_W-1:0] op_ext;
    logic signed [ACC_W-1:0] contrib_l;
    logic signed [ACC_W-1:0] contrib_r;
    logic signed [ACC_W-1:0] acc_l_q;
    logic signed [ACC_W-1:0] acc_l_d;
    logic signed [ACC_W-1:0] acc_r_q;
    logic signed [ACC_W-1:0] acc_r_d;
    logic signed [OUT_W-1:0] sat_l;
    logic signed [OUT_W-1:0] sat_r;
    logic signed [OUT_W-1:0] left_q;
    logic signed [OUT_W-1:0] left_d;
    logic signed [OUT_W-1:0] right_q;
    logic signed [OUT_W-1:0] right_d;

    always_comb begin
        sum_en = 1'b0;
        case (acc_if.alg)
            ALG_0, ALG_1, ALG_2, ALG_3: sum_en = acc_if.s4_enters;
            ALG_4:                      sum_en = acc_if.s2_enters | acc_if.s4_enters;
            ALG_5, ALG_6:               sum_en = acc_if.s2_enters | acc_if.s3_enters
                                               | acc_if.s4_enters;
            ALG_7:                      sum_en = acc_if.s1_enters | acc_if.s2_enters
                                               | acc_if.s3_enters | acc_if.s4_enters;
            default:                    sum_en = 1'b0;
        endcase
    end

    assign op_ext    = {{(ACC_W-OP_W){acc_if.op_result[OP_W-1]}}, acc_if.op_result};
    assign contrib_l = (sum_en & acc_if.rl[1]) ? op_ext : '0;
    assign contrib_r = (sum_en & acc_if.rl[0]) ? op_ext : '0;

    // The first S1 slot opens a new frame; its own contribution belongs to the new frame.
    assign frame_start = acc_if.s1_enters & ~s1_last_q;

    always_comb begin
        acc_l_d = acc_l_q + contrib_l;
        acc_r_d = acc_r_q + contrib_r;
        left_d  = left_q;
        right_d = right_q;
        if (frame_start) begin
            acc_l_d = contrib_l;
            acc_r_d = contrib_r;
            left_d  = sat_l;
            right_d = sat_r;
        end
    end

    jt12_sat16 #(.ACC_W(ACC_W)) u_sat_l (
        .din_i  (acc_l_q),
        .dout_o (sat_l)
    );

    jt12_sat16 #(.ACC_W(ACC_W)) u_sat_r (
        .din_i  (acc_r_q),
        .dout_o (sat_r)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_last_q <= 1'b0;
            acc_l_q   <= '0;
            acc_r_q   <= '0;
            left_q    <= '0;
            right_q   <= '0;
        end else begin
            s1_last_q <= acc_if.s1_enters;
            acc_l_q   <= acc_l_d;
            acc_r_q   <= acc_r_d;
            left_q    <= left_d;
            right_q   <= right_d;
        end
    end

    assign acc_if.left  = left_q;
    assign acc_if.right = right_q;

endmodule

// File: tb/tb_jt12_accumulator.sv
// Scoreboard bench for the FM output mixer: a per-frame model predicts each stereo sample.
module tb_jt12_accumulator;
    import jt12_pkg::*;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    jt12_accumulator_if acc_if();

    jt12_accumulator #(.ACC_W(19)) dut (
        .clk    (clk),
        .rst    (rst),
        .acc_if (acc_if.slave)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int sb_l[$];
    int sb_r[$];
    int run_l = 0;
    int run_r = 0;
    int hold_l = 0;
    int hold_r = 0;
    bit prev_s1 = 1'b0;

    task automatic check(input string tag, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d", tag, act, exp);
        end
    endtask

    function automatic bit is_carrier(input int alg_v, input int grp);
        bit [3:0] m;
        case (alg_v)
            0, 1, 2, 3: m = 4'b1000;
            4:          m = 4'b1010;
            5, 6:       m = 4'b1110;
            default:    m = 4'b1111;
        endcase
        if (grp < 1 || grp > 4) return 1'b0;
        return m[grp-1];
    endfunction

    function automatic int sat16(input int v);
        if (v > 32767)  return 32767;
        if (v < -32768) return -32768;
        return v;
    endfunction

    // Drive one slot; a frame-opening slot closes the modelled frame onto the scoreboard.
    task automatic slot(input int grp, input int op, input int alg_v, input logic [1:0] rl_v);
        bit fs;
        int c;
        acc_if.op_result = 14'(op);
        acc_if.rl        = rl_v;
        acc_if.alg       = 3'(alg_v);
        acc_if.s1_enters = (grp == 1);
        acc_if.s2_enters = (grp == 2);
        acc_if.s3_enters = (grp == 3);
        acc_if.s4_enters = (grp == 4);
        fs = (grp == 1) && !prev_s1;
        if (fs) begin
            sb_l.push_back(sat16(run_l));
            sb_r.push_back(sat16(run_r));
            run_l = 0;
            run_r = 0;
        end
        c = is_carrier(alg_v, grp) ? op : 0;
        if (rl_v[1]) run_l += c;
        if (rl_v[0]) run_r += c;
        prev_s1 = (grp == 1);
        @(posedge clk);
        #1;
        if (fs) begin
            hold_l = sb_l.pop_front();
            hold_r = sb_r.pop_front();
            check("frame_l", int'(acc_if.left), hold_l);
            check("frame_r", int'(acc_if.right), hold_r);
        end else begin
            check("hold_l", int'(acc_if.left), hold_l);
            check("hold_r", int'(acc_if.right), hold_r);
        end
    endtask

    task automatic frame(input int alg_v,
                         input int op1, input logic [1:0] rl1,
                         input int op2, input logic [1:0] rl2,
                         input int op3, input logic [1:0] rl3,
                         input int op4, input logic [1:0] rl4);
        for (int i = 0; i < 6; i++) slot(1, op1, alg_v, rl1);
        for (int i = 0; i < 6; i++) slot(2, op2, alg_v, rl2);
        for (int i = 0; i < 6; i++) slot(3, op3, alg_v, rl3);
        for (int i = 0; i < 6; i++) slot(4, op4, alg_v, rl4);
    endtask

    task automatic uframe(input int alg_v, input int op, input logic [1:0] rl_v, input int n);
        for (int k = 0; k < n; k++) frame(alg_v, op, rl_v, op, rl_v, op, rl_v, op, rl_v);
    endtask

    initial begin
        rst              = 1'b0;
        acc_if.op_result = '0;
        acc_if.rl        = 2'b00;
        acc_if.alg       = 3'd0;
        acc_if.s1_enters = 1'b0;
        acc_if.s2_enters = 1'b0;
        acc_if.s3_enters = 1'b0;
        acc_if.s4_enters = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_l", int'(acc_if.left), 0);
        check("rst_r", int'(acc_if.right), 0);
        rst = 1'b1;

        uframe(0, 100, 2'b11, 3);
        uframe(7, 100, 2'b10, 2);
        uframe(4, 100, 2'b10, 2);
        uframe(5, 100, 2'b10, 2);
        uframe(7, 8191, 2'b11, 2);
        uframe(7, -8192, 2'b11, 2);
        frame(4, 999, 2'b11, 500, 2'b01, 999, 2'b11, -300, 2'b11);
        frame(4, 999, 2'b11, 500, 2'b01, 999, 2'b11, -300, 2'b11);

        // Boundary: a carrier in the frame-opening slot lands in the next sample.
        uframe(7, 0, 2'b11, 1);
        for (int i = 0; i < 24; i++) slot(i / 6 + 1, (i == 0) ? 1000 : 0, 7, 2'b11);
        uframe(7, 0, 2'b11, 1);

        // Reset mid-frame, held for two slots, then a partial frame after release.
        for (int i = 0; i < 10; i++) slot(i / 6 + 1, 100, 7, 2'b11);
        rst = 1'b0;
        #1;
        check("rst_imm_l", int'(acc_if.left), 0);
        check("rst_imm_r", int'(acc_if.right), 0);
        hold_l = 0;
        hold_r = 0;
        sb_l.delete();
        sb_r.delete();
        for (int i = 10; i < 12; i++) slot(i / 6 + 1, 100, 7, 2'b11);
        rst     = 1'b1;
        run_l   = 0;
        run_r   = 0;
        prev_s1 = 1'b0;
        for (int i = 12; i < 24; i++) slot(i / 6 + 1, 7, 7, 2'b11);
        uframe(7, 100, 2'b11, 1);
        slot(1, 0, 0, 2'b00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
